digit_sequence_monitor: RTL and testbench
=========================================

# digit_sequence_monitor

Receive-side checker for the one-hot digit-select stream that drives the display's digit enables. It samples the 4-bit one-hot pattern every `clk5Hz` tick and converts it to a binary digit index. It verifies that the pattern walks 0→1→2→3→0 one step per tick, and counts completed laps. It sits next to the digit sequencer and feeds the reaction-timer control logic and the debug LEDs.

## Interface
Parameters:
- `LAP_W`, 8, width of the lap counter; saturates at 2^LAP_W−1.

Ports:
- `clk5Hz` in 1: sole clock, all state on its rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `z_in` in 4: one-hot digit-select stream; bit k = digit k; 4'b0000 = blank.
- `clr` in 1: synchronous clear of `err_code` and `lap_count`.
- `idx` out 2: binary index of the current digit.
- `idx_valid` out 1: high when `idx` reflects an accepted, in-sequence digit.
- `lap_done` out 1: one-cycle pulse on each 3→0 wrap.
- `lap_count` out LAP_W: number of completed laps, saturating.
- `err_code` out 2: sticky first error. 00 none, 01 multi-hot, 10 skip/repeat, 11 bad start.
- `seq_error` out 1: equals `|err_code`.

## Operation
- States: IDLE, TRACK, FAULT. Reset state is IDLE.
- Each edge, classify `z_in`:
  - ZERO: `z_in` = 0.
  - ONEHOT: exactly one bit set; k = its position.
  - MULTI: any other value.
- IDLE:
  - ZERO → stay in IDLE.
  - ONEHOT with start accepted (see Configuration) → TRACK; `idx`=k, `idx_valid`=1.
  - ONEHOT with start not accepted → FAULT; error 11.
  - MULTI → FAULT; error 01.
- TRACK (prev = last accepted index):
  - ONEHOT with k == prev+1 mod 4 → stay in TRACK; `idx`=k.
    - If prev=3 and k=0: pulse `lap_done`; `lap_count`+1, saturating.
  - ONEHOT with any other k (including k == prev) → FAULT; error 10.
  - MULTI → FAULT; error 01.
  - ZERO → IDLE; `idx_valid`=0; `idx` holds its last value.
- FAULT:
  - `idx_valid`=0. All non-ZERO inputs are ignored and record no further errors.
  - ZERO → IDLE.
- `err_code` latches only the first error. Later errors do not overwrite it until `clr` or reset.
- `clr`:
  - Zeroes `err_code` and `lap_count` on the same edge. Does not change state.
  - If an error and `clr` occur on the same edge, `clr` wins: `err_code` ends at 00.
  - If a wrap and `clr` occur on the same edge, `lap_count` ends at 0 and `lap_done` still pulses.
- Reset values: `idx`=0, `idx_valid`=0, `lap_done`=0, `lap_count`=0, `err_code`=00, state IDLE.

## Timing
- All outputs are registered. Latency is one cycle: the `z_in` value sampled at edge n appears on the outputs after edge n.
- `lap_done` is high for exactly one cycle per wrap.
- The counter holds at max while `lap_done` continues to pulse on each wrap.
- Asserting `reset_n` low mid-lap clears all outputs immediately, without waiting for a clock. After release, the first non-zero `z_in` is treated as a fresh start.
- `z_in` must be synchronous to `clk5Hz`. The block adds no synchronizer.

## Configuration
- Macro: `DSM_STRICT_START_EN`.
- Defined: from IDLE, only k=0 (4'b0001) is accepted. Any other one-hot start gives FAULT with error 11.
- Undefined: any one-hot value is accepted as a start in IDLE. Error code 11 is never produced.

## Test plan
- Reset, then `z_in` = 0001, 0010, 0100, 1000, 0001 → `idx` 0,1,2,3,0 with `idx_valid`=1. One `lap_done` pulse; `lap_count`=1; `err_code`=00.
- Walk in progress, then `z_in`=0000 → `idx_valid`=0, state IDLE, no error. Restart from 0001 → tracking resumes with `lap_count` preserved.
- In TRACK at idx 1, `z_in`=1000 → FAULT, `err_code`=10. Then `z_in`=0011 → `err_code` stays 10. Then 0000 followed by `clr` → `err_code`=00.
- From IDLE, `z_in`=0110 → `err_code`=01, `idx_valid`=0.
- With `DSM_STRICT_START_EN` defined, start at 0100 → `err_code`=11. Without the macro, the same stimulus → `idx`=2, `idx_valid`=1.
- `LAP_W`=2, run 5 laps → `lap_count` saturates at 3 and `lap_done` pulses 5 times. Drop `reset_n` mid-lap asynchronously → all outputs 0 before the next edge.

Source files
------------

// File: rtl/digit_sequence_monitor.sv
// Receive-side checker for the one-hot digit-select stream: tracks the 0->1->2->3->0 walk,
// counts laps and latches the first error. Optional macro DSM_STRICT_START_EN accepts only digit 0 as a start.
module digit_sequence_monitor #(
  parameter int LAP_W = 8
) (
  input  logic             clk5Hz,
  input  logic             reset_n,
  input  logic [3:0]       z_in,
  input  logic             clr,
  output logic [1:0]       idx,
  output logic             idx_valid,
  output logic             lap_done,
  output logic [LAP_W-1:0] lap_count,
  output logic [1:0]       err_code,
  output logic             seq_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [1:0]       ERR_NONE  = 2'b00;
  localparam logic [1:0]       ERR_MULTI = 2'b01;
  localparam logic [1:0]       ERR_STEP  = 2'b10;
  localparam logic [1:0]       ERR_START = 2'b11;
  localparam logic [LAP_W-1:0] LAP_MAX   = {LAP_W{1'b1}};
  localparam logic [LAP_W-1:0] LAP_ONE   = {{(LAP_W-1){1'b0}}, 1'b1};

  function automatic logic [2:0] ones_count(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [1:0] onehot_pos(input logic [3:0] v);
    logic [1:0] pos;
    case (v)
      4'b0001: pos = 2'd0;
      4'b0010: pos = 2'd1;
      4'b0100: pos = 2'd2;
      4'b1000: pos = 2'd3;
      default: pos = 2'd0;
    endcase
    return pos;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [1:0]       idx_r;
  logic             idx_valid_r;
  logic             lap_done_r;
  logic [LAP_W-1:0] lap_count_r;
  logic [1:0]       err_code_r;
  logic             seq_error_r;

  logic             zero_s;
  logic             onehot_s;
  logic             multi_s;
  logic [1:0]       k_s;
  logic             step_ok_s;
  logic             start_ok_s;
  logic [1:0]       idx_nxt_s;
  logic             idx_valid_nxt_s;
  logic             wrap_s;
  logic [1:0]       err_new_s;
  logic [1:0]       err_nxt_s;
  logic [LAP_W-1:0] lap_nxt_s;

  assign zero_s    = (z_in == 4'b0000);
  assign onehot_s  = (ones_count(z_in) == 3'd1);
  assign multi_s   = !zero_s && !onehot_s;
  assign k_s       = onehot_pos(z_in);
  // 2-bit addition wraps 3 -> 0 naturally
  assign step_ok_s = (k_s == (idx_r + 2'd1));

`ifdef DSM_STRICT_START_EN
  assign start_ok_s = (k_s == 2'd0);
`else
  assign start_ok_s = 1'b1;
`endif

  // State register
  always_ff @(posedge clk5Hz or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode from the classified input
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (zero_s) begin
          state_nxt_s = IDLE;
        end else if (onehot_s && start_ok_s) begin
          state_nxt_s = TRACK;
        end else begin
          state_nxt_s = FAULT;
        end
      end
      TRACK: begin
        if (zero_s) begin
          state_nxt_s = IDLE;
        end else if (onehot_s && step_ok_s) begin
          state_nxt_s = TRACK;
        end else begin
          state_nxt_s = FAULT;
        end
      end
      FAULT: begin
        if (zero_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FAULT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next output values; clr overrides both the error latch and the lap counter
  always_comb begin
    idx_nxt_s       = idx_r;
    idx_valid_nxt_s = 1'b0;
    wrap_s          = 1'b0;
    err_new_s       = ERR_NONE;
    case (state_r)
      IDLE: begin
        if (onehot_s && start_ok_s) begin
          idx_nxt_s       = k_s;
          idx_valid_nxt_s = 1'b1;
        end else if (onehot_s) begin
          err_new_s = ERR_START;
        end else if (multi_s) begin
          err_new_s = ERR_MULTI;
        end else begin
          err_new_s = ERR_NONE;
        end
      end
      TRACK: begin
        if (onehot_s && step_ok_s) begin
          idx_nxt_s       = k_s;
          idx_valid_nxt_s = 1'b1;
          wrap_s          = (idx_r == 2'd3);
        end else if (onehot_s) begin
          err_new_s = ERR_STEP;
        end else if (multi_s) begin
          err_new_s = ERR_MULTI;
        end else begin
          err_new_s = ERR_NONE;
        end
      end
      FAULT:   err_new_s = ERR_NONE;
      default: err_new_s = ERR_NONE;
    endcase

    if (clr) begin
      err_nxt_s = ERR_NONE;
      lap_nxt_s = {LAP_W{1'b0}};
    end else begin
      err_nxt_s = (err_code_r == ERR_NONE) ? err_new_s : err_code_r;
      if (wrap_s && (lap_count_r != LAP_MAX)) begin
        lap_nxt_s = lap_count_r + LAP_ONE;
      end else begin
        lap_nxt_s = lap_count_r;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk5Hz or negedge reset_n) begin
    if (!reset_n) begin
      idx_r       <= 2'd0;
      idx_valid_r <= 1'b0;
      lap_done_r  <= 1'b0;
      lap_count_r <= {LAP_W{1'b0}};
      err_code_r  <= ERR_NONE;
      seq_error_r <= 1'b0;
    end else begin
      idx_r       <= idx_nxt_s;
      idx_valid_r <= idx_valid_nxt_s;
      lap_done_r  <= wrap_s;
      lap_count_r <= lap_nxt_s;
      err_code_r  <= err_nxt_s;
      seq_error_r <= |err_nxt_s;
    end
  end

  assign idx       = idx_r;
  assign idx_valid = idx_valid_r;
  assign lap_done  = lap_done_r;
  assign lap_count = lap_count_r;
  assign err_code  = err_code_r;
  assign seq_error = seq_error_r;

endmodule

// File: tb/tb_digit_sequence_monitor.sv
// Scoreboard bench for digit_sequence_monitor: a behavioural model predicts each cycle's outputs,
// a separate monitor compares them one cycle after the stimulus edge.
`timescale 1ns/1ps
module tb_digit_sequence_monitor;

  localparam int LAP_W   = 2;
  localparam int LAP_MAX = (1 << LAP_W) - 1;

  logic             clk5Hz  = 1'b0;
  logic             reset_n = 1'b0;
  logic [3:0]       z_in    = 4'b0000;
  logic             clr     = 1'b0;
  logic [1:0]       idx;
  logic             idx_valid;
  logic             lap_done;
  logic [LAP_W-1:0] lap_count;
  logic [1:0]       err_code;
  logic             seq_error;

  digit_sequence_monitor #(.LAP_W(LAP_W)) dut (
    .clk5Hz    (clk5Hz),
    .reset_n   (reset_n),
    .z_in      (z_in),
    .clr       (clr),
    .idx       (idx),
    .idx_valid (idx_valid),
    .lap_done  (lap_done),
    .lap_count (lap_count),
    .err_code  (err_code),
    .seq_error (seq_error)
  );

  always #5 clk5Hz = ~clk5Hz;

  typedef struct packed {
    logic [1:0]       idx;
    logic             valid;
    logic             done;
    logic [LAP_W-1:0] laps;
    logic [1:0]       err;
    logic             serr;
  } obs_t;

  obs_t exp_q[$];
  int   checks      = 0;
  int   passes      = 0;
  int   exp_pulses  = 0;
  int   got_pulses  = 0;
  bit   stim_done   = 1'b0;

  // Model: waiting for a start, halted after an error, or tracking the digit it wants next.
  bit strict       = 1'b0;
  bit m_wait_start = 1'b1;
  bit m_halted     = 1'b0;
  int m_want       = 0;
  int m_idx        = 0;
  int m_laps       = 0;
  int m_err        = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
  endtask

  task automatic model_reset();
    m_wait_start = 1'b1;
    m_halted     = 1'b0;
    m_want       = 0;
    m_idx        = 0;
    m_laps       = 0;
    m_err        = 0;
  endtask

  task automatic model_step(input logic [3:0] z, input bit c, output obs_t e);
    int ones;
    int k;
    int new_err;
    bit valid;
    bit done;
    ones = $countones(z);
    k = 0;
    for (int b = 0; b < 4; b++) if (z[b]) k = b;
    new_err = 0;
    valid   = 1'b0;
    done    = 1'b0;
    if (m_halted) begin
      if (z == 4'b0000) begin
        m_halted     = 1'b0;
        m_wait_start = 1'b1;
      end
    end else if (m_wait_start) begin
      if (ones > 1) begin
        new_err = 1; m_halted = 1'b1;
      end else if (ones == 1) begin
        if (strict && k != 0) begin
          new_err = 3; m_halted = 1'b1;
        end else begin
          m_idx = k; valid = 1'b1; m_wait_start = 1'b0; m_want = (k + 1) % 4;
        end
      end
    end else begin
      if (z == 4'b0000) begin
        m_wait_start = 1'b1;
      end else if (ones > 1) begin
        new_err = 1; m_halted = 1'b1;
      end else if (k == m_want) begin
        m_idx = k; valid = 1'b1; m_want = (k + 1) % 4;
        if (k == 0) begin
          done = 1'b1;
          if (m_laps < LAP_MAX) m_laps++;
        end
      end else begin
        new_err = 2; m_halted = 1'b1;
      end
    end
    if (m_err == 0) m_err = new_err;
    if (c) begin
      m_err  = 0;
      m_laps = 0;
    end
    e.idx   = 2'(m_idx);
    e.valid = valid;
    e.done  = done;
    e.laps  = LAP_W'(m_laps);
    e.err   = 2'(m_err);
    e.serr  = (m_err != 0);
  endtask

  task automatic step(input logic [3:0] z, input bit c);
    obs_t e;
    @(negedge clk5Hz);
    z_in = z;
    clr  = c;
    model_step(z, c, e);
    exp_q.push_back(e);
    if (e.done) exp_pulses++;
  endtask

  task automatic walk_lap();
    step(4'b0010, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b0001, 1'b0);
  endtask

  task automatic async_reset();
    @(posedge clk5Hz);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_zero", 32'({idx, idx_valid, lap_done, lap_count, err_code, seq_error}), 32'd0);
    model_reset();
    @(negedge clk5Hz);
    z_in = 4'b0000;
    clr  = 1'b0;
    @(negedge clk5Hz);
    reset_n = 1'b1;
  endtask

  // Monitor: compare DUT outputs against the oldest queued prediction after each edge
  initial begin
    obs_t e;
    obs_t g;
    forever begin
      @(posedge clk5Hz);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        g = {idx, idx_valid, lap_done, lap_count, err_code, seq_error};
        if (lap_done) got_pulses++;
        check("outputs", 32'(g), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] one;
    logic [3:0] z;
    int         r;
    bit         c;
`ifdef DSM_STRICT_START_EN
    strict = 1'b1;
`endif
    one = 4'b0001;
    repeat (2) @(negedge clk5Hz);
    check("reset_state", 32'({idx, idx_valid, lap_done, lap_count, err_code, seq_error}), 32'd0);
    reset_n = 1'b1;

    step(4'b0001, 1'b0);
    walk_lap();
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b0011, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0110, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0);
    for (int i = 0; i < 5; i++) walk_lap();
    step(4'b0010, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    async_reset();
    step(4'b0100, 1'b0);
    step(4'b1000, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 65)      z = one << m_want;
      else if (r < 75) z = 4'b0000;
      else if (r < 85) z = one << $urandom_range(0, 3);
      else             z = 4'($urandom_range(0, 15));
      c = ($urandom_range(0, 49) == 0);
      step(z, c);
      if (i == 700) async_reset();
    end

    step(4'b0000, 1'b0);
    repeat (3) @(negedge clk5Hz);
    stim_done = 1'b1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("lap_pulses", 32'(got_pulses), 32'(exp_pulses));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
